// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential wide-word comparator.
package cmp_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_flags_t;

    // True when exactly one of the three comparator flags is set.
    function automatic logic onehot3(input cmp_flags_t f);
        return ( f.gt & ~f.lt & ~f.eq) |
               (~f.gt &  f.lt & ~f.eq) |
               (~f.gt & ~f.lt &  f.eq);
    endfunction

endpackage

// File: rtl/nib_sel.sv
// Selects one 4-bit nibble out of a WIDTH-bit word; idx 0 is the least significant nibble.
module nib_sel
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] word,
    input  logic [IDX_W-1:0] idx,
    output logic [NIB_W-1:0] nib
);

    localparam int NNIB = WIDTH / NIB_W;

    // Plain slice mux over every nibble position.
    // NOTE: give every always_comb output a value before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        nib = '0;
        for (int i = 0; i < NNIB; i++) begin
            if (idx == IDX_W'(i)) begin
                nib = word[i*NIB_W +: NIB_W];
            end
        end
    end

endmodule

// File: rtl/word_cmp_seq.sv
// Sequential wide-word magnitude comparator: walks the operands MSB nibble first
// through an external 4-bit comparator and returns one registered gt/lt/eq result.
module word_cmp_seq
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [NIB_W-1:0] nib_a,
    output logic [NIB_W-1:0] nib_b,
    output logic             nib_valid,
    input  logic             cmp_agt,
    input  logic             cmp_alt,
    input  logic             cmp_aeq,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             res_gt,
    output logic             res_lt,
    output logic             res_eq,
    output logic             res_err
);

    localparam int NNIB  = WIDTH / NIB_W;
    localparam int IDX_W = $clog2(NNIB);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NNIB - 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [IDX_W-1:0] idx;
    logic             dec_gt;
    logic             dec_lt;
    logic             err;
    cmp_flags_t       res;
    logic             res_err_q;

    logic             accept;
    cmp_flags_t       flags;
    logic             flags_ok;
    logic             eff_gt;
    logic             eff_lt;
    logic             decided;
    logic             fin;
    logic             fin_gt;
    logic             fin_lt;
    logic [NIB_W-1:0] sel_a;
    logic [NIB_W-1:0] sel_b;

    nib_sel #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_sel_a (.word(op_a), .idx(idx), .nib(sel_a));
    nib_sel #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_sel_b (.word(op_b), .idx(idx), .nib(sel_b));

    // Handshakes; requests seen while rst is high never get a ready.
    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign nib_valid = (state == CMP);
    assign nib_a     = nib_valid ? sel_a : '0;
    assign nib_b     = nib_valid ? sel_b : '0;

    // Per-nibble decision: a non-one-hot flag set counts as an equal nibble.
    assign flags    = '{gt: cmp_agt, lt: cmp_alt, eq: cmp_aeq};
    assign flags_ok = onehot3(flags);
    assign eff_gt   = flags_ok & cmp_agt;
    assign eff_lt   = flags_ok & cmp_alt;
    assign decided  = dec_gt | dec_lt;
    assign fin      = (state == CMP) && ((idx == '0) || (EARLY_EXIT && (eff_gt || eff_lt)));
    // The first recorded unequal nibble wins over anything seen later.
    assign fin_gt   = decided ? dec_gt : eff_gt;
    assign fin_lt   = decided ? dec_lt : eff_lt;

    assign res_gt  = res.gt;
    assign res_lt  = res.lt;
    assign res_eq  = res.eq;
    assign res_err = res_err_q;

    // Next-state logic for IDLE -> CMP -> DONE -> IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept)    state_n = CMP;
            CMP:     if (fin)       state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default:                state_n = IDLE;
        endcase
    end

    // State register with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Operand capture, nibble index walk, first-decision tracking and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            idx       <= IDX_MSB;
            dec_gt    <= 1'b0;
            dec_lt    <= 1'b0;
            err       <= 1'b0;
            res       <= '0;
            res_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a   <= in_a;
                        op_b   <= in_b;
                        idx    <= IDX_MSB;
                        dec_gt <= 1'b0;
                        dec_lt <= 1'b0;
                        err    <= 1'b0;
                    end
                end
                CMP: begin
                    if (!flags_ok) err <= 1'b1;
                    if (!decided) begin
                        dec_gt <= eff_gt;
                        dec_lt <= eff_lt;
                    end
                    if (fin) begin
                        res       <= '{gt: fin_gt, lt: fin_lt, eq: !(fin_gt || fin_lt)};
                        res_err_q <= err | !flags_ok;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        res       <= '0;
                        res_err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_word_cmp_seq.sv
// Directed bench for word_cmp_seq: one early-exit and one constant-latency instance,
// each wired to a behavioural 4-bit comparator with an optional flag-corruption hook.
module tb_word_cmp_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [1:0]  out_ready;
    logic [1:0]  inj;
    logic [15:0] in_a [2];
    logic [15:0] in_b [2];
    wire  [1:0]  in_ready, nib_valid, out_valid;
    wire  [1:0]  agt, alt, aeq;
    wire  [1:0]  res_gt, res_lt, res_eq, res_err;
    wire  [3:0]  nib_a [2];
    wire  [3:0]  nib_b [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural comparator; hit forces eq alongside gt on the 5-vs-3 nibble.
    for (genvar g = 0; g < 2; g++) begin : g_cmp
        wire hit;
        assign hit    = inj[g] & nib_valid[g] & (nib_a[g] == 4'h5) & (nib_b[g] == 4'h3);
        assign agt[g] = (nib_a[g] >  nib_b[g]) | hit;
        assign alt[g] = (nib_a[g] <  nib_b[g]);
        assign aeq[g] = (nib_a[g] == nib_b[g]) | hit;
    end

    word_cmp_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
        .nib_a(nib_a[0]), .nib_b(nib_b[0]), .nib_valid(nib_valid[0]),
        .cmp_agt(agt[0]), .cmp_alt(alt[0]), .cmp_aeq(aeq[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .res_gt(res_gt[0]), .res_lt(res_lt[0]), .res_eq(res_eq[0]), .res_err(res_err[0])
    );

    word_cmp_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_ce (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
        .nib_a(nib_a[1]), .nib_b(nib_b[1]), .nib_valid(nib_valid[1]),
        .cmp_agt(agt[1]), .cmp_alt(alt[1]), .cmp_aeq(aeq[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .res_gt(res_gt[1]), .res_lt(res_lt[1]), .res_eq(res_eq[1]), .res_err(res_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One transaction on unit u; exp_res is {gt,lt,eq}; latency counted in cycles from the accept cycle.
    task automatic run_op(input int u, input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] exp_res, input logic exp_err, input int exp_lat,
                          input int exp_nibs, input int hold, output logic [15:0] seq);
        int   lat;
        int   nibs;
        logic stable;
        @(negedge clk);
        check({tag, "_rdy"}, 32'(in_ready[u]), 32'd1);
        in_a[u]     = a;
        in_b[u]     = b;
        in_valid[u] = 1'b1;
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        check({tag, "_busy"}, 32'(in_ready[u]), 32'd0);
        lat  = 1;
        nibs = 0;
        seq  = '0;
        while (!out_valid[u] && lat < 40) begin
            if (nib_valid[u]) begin
                seq = {seq[11:0], nib_a[u]};
                nibs++;
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_nibs"}, 32'(nibs), 32'(exp_nibs));
        check({tag, "_res"}, 32'({res_gt[u], res_lt[u], res_eq[u]}), 32'(exp_res));
        check({tag, "_err"}, 32'(res_err[u]), 32'(exp_err));
        check({tag, "_nv"}, 32'({in_ready[u], nib_valid[u]}), 32'd0);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid[u] || in_ready[u] || ({res_gt[u], res_lt[u], res_eq[u]} !== exp_res) ||
                (res_err[u] !== exp_err))
                stable = 1'b0;
        end
        if (hold > 0) check({tag, "_hold"}, 32'(stable), 32'd1);
        @(negedge clk);
        out_ready[u] = 1'b1;
        @(posedge clk); #1;
        out_ready[u] = 1'b0;
        check({tag, "_clr"}, 32'({out_valid[u], res_gt[u], res_lt[u], res_eq[u], res_err[u]}), 32'd0);
        check({tag, "_idle"}, 32'(in_ready[u]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] seq;
        rst       = 1'b1;
        in_valid  = 2'b11;
        out_ready = 2'b00;
        inj       = 2'b00;
        for (int u = 0; u < 2; u++) begin
            in_a[u] = 16'h1111;
            in_b[u] = 16'h2222;
        end

        // Reset state; requests during reset must not start a compare.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_outv", 32'(out_valid), 32'd0);
        check("rst_nibv", 32'(nib_valid), 32'd0);
        check("rst_nib", 32'({nib_a[0], nib_b[0], nib_a[1], nib_b[1]}), 32'd0);
        check("rst_res", 32'({res_gt, res_lt, res_eq, res_err}), 32'd0);
        @(negedge clk);
        in_valid = 2'b00;
        rst      = 1'b0;
        #1;
        check("rel_ready", 32'(in_ready), 32'd3);

        // out_ready with no result pending does nothing.
        @(negedge clk);
        out_ready = 2'b11;
        @(posedge clk); #1;
        check("oready_idle", 32'({in_ready, out_valid}), 32'b1100);
        out_ready = 2'b00;

        // Early-exit instance.
        run_op(0, "t1_eq",   16'h1234, 16'h1234, 3'b001, 1'b0, 5, 4, 0, seq);
        run_op(0, "t2_gt",   16'h8000, 16'h7FFF, 3'b100, 1'b0, 2, 1, 0, seq);
        run_op(0, "t3_lt",   16'h12F0, 16'h12F1, 3'b010, 1'b0, 5, 4, 0, seq);
        check("t3_seq", 32'(seq), 32'h12F0);
        run_op(0, "t5_hold", 16'hA5A5, 16'hA5B5, 3'b010, 1'b0, 4, 3, 10, seq);
        check("t5_seq", 32'(seq), 32'h0A5A);
        run_op(0, "zero",    16'h0000, 16'h0000, 3'b001, 1'b0, 5, 4, 0, seq);
        run_op(0, "ones",    16'hFFFF, 16'hFFFF, 3'b001, 1'b0, 5, 4, 0, seq);
        inj[0] = 1'b1;
        run_op(0, "err",     16'h5312, 16'h3312, 3'b001, 1'b1, 5, 4, 0, seq);
        inj[0] = 1'b0;
        run_op(0, "post_err", 16'h0F00, 16'h0E00, 3'b100, 1'b0, 3, 2, 0, seq);

        // Constant-latency instance.
        run_op(1, "t4_gt",   16'h9000, 16'h1FFF, 3'b100, 1'b0, 5, 4, 0, seq);
        run_op(1, "ce_lt",   16'h1FFF, 16'h2000, 3'b010, 1'b0, 5, 4, 0, seq);
        run_op(1, "ce_eq",   16'hBEEF, 16'hBEEF, 3'b001, 1'b0, 5, 4, 0, seq);

        // Reset in the middle of a compare aborts it.
        @(negedge clk);
        in_a[0]     = 16'h1234;
        in_b[0]     = 16'h1234;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        check("t6_nib2", 32'({nib_valid[0], nib_a[0]}), 32'h12);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_abort", 32'({nib_valid[0], out_valid[0], in_ready[0]}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("t6_hold_rdy", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_rdy", 32'(in_ready[0]), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("t6_no_res", 32'({out_valid[0], nib_valid[0]}), 32'd0);
        run_op(0, "t6_after", 16'h0001, 16'h0002, 3'b010, 1'b0, 5, 4, 0, seq);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
